// File: rtl/uart_pkg.sv
// Shared types and constants for the RS232 UART transmitter.
// UART_TX_PARITY_EN enables the parity stage in rs232_uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; head word is always visible on rd_data.
// Pointers wrap modulo DEPTH; count carries one extra bit to tell full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/rs232_uart_tx.sv
// RS232 8-bit UART transmitter: FIFO-buffered, LSB first, paced by an external baud clock.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module rs232_uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          fin,
    input  logic                          rst_n,
    input  logic                          baud_in,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_t                     state_dbg
);

    // Handshake: a byte is taken on any fin edge where in_valid && in_ready are both high.

    logic                 baud_s1, baud_s2, baud_d;
    logic                 tick;
    logic                 fifo_full, fifo_empty, pop;
    logic [DATA_BITS-1:0] fifo_head;

    tx_state_t            state, state_n;
    logic                 txd_r, txd_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
`ifdef UART_TX_PARITY_EN
    logic                 par_r, par_n;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (fin),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign txd       = txd_r;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // baud_in is asynchronous: two flops to resolve metastability, a third to find the rising edge.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            baud_s1 <= 1'b0;
            baud_s2 <= 1'b0;
            baud_d  <= 1'b0;
        end else begin
            baud_s1 <= baud_in;
            baud_s2 <= baud_s1;
            baud_d  <= baud_s2;
        end
    end

    assign tick = baud_s2 && !baud_d;

    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            txd_r    <= IDLE_LVL;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            txd_r    <= txd_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
`ifdef UART_TX_PARITY_EN
            par_r    <= par_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        txd_n      = txd_r;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par_r;
`endif
        case (state)
            IDLE: begin
                txd_n = IDLE_LVL;
                // fifo_empty is registered, so a byte pushed on this same edge waits one tick.
                if (tick && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_head;
                    txd_n   = START_LVL;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = parity_of(fifo_head, PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) begin
                    txd_n     = shift[0];
                    shift_n   = shift >> 1;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        txd_n      = par_r;
                        state_n    = PARITY;
`else
                        txd_n      = IDLE_LVL;
                        stop_cnt_n = 1'b0;
                        state_n    = STOP;
`endif
                    end else begin
                        txd_n     = shift[0];
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    txd_n      = IDLE_LVL;
                    stop_cnt_n = 1'b0;
                    state_n    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        // Back-to-back frames: the next start bit replaces the idle gap.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_n = fifo_head;
                            txd_n   = START_LVL;
                            state_n = START;
`ifdef UART_TX_PARITY_EN
                            par_n   = parity_of(fifo_head, PARITY_ODD != 0);
`endif
                        end else begin
                            txd_n   = IDLE_LVL;
                            state_n = IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                txd_n   = IDLE_LVL;
                state_n = IDLE;
            end
        endcase
    end

endmodule
